mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  system clock; reset nRST, asynchronous, active-low; clock CLK.
REQ-002 nRST  in  1  async active-low reset.
REQ-003 ex_valid  in  1  EX/MEM holds a live instruction.
REQ-004 ex_dREN, ex_dWEN  in  1 each  load / store request from EX/MEM.
REQ-005 ex_opcode  in  opcode_t (6)  instruction opcode (LW, SW, LL, SC, others).
REQ-006 ex_aluout, ex_store  in  word_t (32)  effective address / store data.
REQ-007 ex_regWrite, ex_memtoReg, ex_halt  in  1 each  control bits passed to writeback.
REQ-008 ex_wsel  in  regbits_t (5)  destination register.
REQ-009 dhit  in  1  data-cache access complete; dmemload  in  32  read data.
REQ-010 snoop_inv  in  1  coherence invalidate valid; snoop_addr  in  32  invalidated word address.
REQ-011 dmemREN, dmemWEN  out  1 each  cache request; dmemaddr, dmemstore  out  32.
REQ-012 wb_regWrite, wb_memtoReg, wb_halt  out  1; wb_readData, wb_aluout  out  32; wb_wsel  out  5; wb_opcode  out  6  next-state values for the MEM/WB register.
REQ-013 memwb_en  out  1  MEM/WB capture enable; stall_up  out  1  freeze IF..EX/MEM.

Function
REQ-014 States: IDLE, WAIT, HALTED (memst_t).
REQ-015 IDLE, ex_valid with no memory op: memwb_en=1 same cycle, no cache request, stall_up=0.
REQ-016 IDLE, ex_valid with LW/LL/SW or SC-with-valid-link: dmemREN/dmemWEN asserted combinationally that cycle; dmemaddr=ex_aluout, dmemstore=ex_store.
REQ-017 Request cycle with dhit=1: memwb_en=1, stall_up=0, remain IDLE (single-cycle hit).
REQ-018 Request cycle with dhit=0: stall_up=1, memwb_en=0, go WAIT.
REQ-019 WAIT: request held every cycle from stable ex_ inputs; stall_up=1 until dhit; on dhit memwb_en=1, stall_up=0, return IDLE.
REQ-020 wb_readData = dmemload for LW/LL; 1 for successful SC; 0 for failed SC; wb_aluout/wb_wsel/wb_opcode/control = ex_ values passthrough.
REQ-021 ex_valid=0: memwb_en=1 with wb_regWrite=0, wb_halt=0 (bubble).
REQ-022 LL completion (dhit): link_valid<=1, link_addr<=ex_aluout.
REQ-023 SC: link evaluated only in issue cycle in IDLE; link_valid && link_addr==ex_aluout -> dmemWEN issued, link_valid<=0 on dhit, readData=1.
REQ-024 SC with failed link: no cache request, wb_readData=0, memwb_en=1 same cycle, link_valid<=0.
REQ-025 snoop_inv with snoop_addr==link_addr clears link_valid; simultaneous with SC issue cycle -> invalidation wins, SC fails.
REQ-026 snoop_inv during SC WAIT does not abort the issued write; SC succeeds.
REQ-027 SW to link_addr by this core clears link_valid on dhit.
REQ-028 memwb_en with ex_halt=1 -> HALTED; HALTED sticky until reset: dmemREN=dmemWEN=0, memwb_en=0, stall_up=1, wb_halt held 1.
REQ-029 dmemREN and dmemWEN never both 1.

Reset
REQ-030 nRST low: state IDLE, link_valid=0, link_addr=0; all outputs 0 except wb_opcode=ADDI; takes effect immediately regardless of state.
REQ-031 Reset mid-WAIT drops request in same cycle; no completion is reported.

Structure
REQ-032 word_t, regbits_t, opcode_t (incl. LL, SC, LW, SW, ADDI), memst_t belong in cpu_types_pkg.
REQ-033 Link register, match and snoop-clear logic in one sub-module llsc_link; FSM and datapath muxing in mem_stage.

Verification
REQ-034 LW 0x100, dhit after 3 wait cycles, dmemload=0xDEADBEEF -> stall_up=1 for 3 cycles, memwb_en=1 on 4th, wb_readData=0xDEADBEEF.
REQ-035 SW 0x200 store 0x12345678, dhit same cycle -> dmemWEN=1, dmemstore=0x12345678, memwb_en=1, stall_up=0.
REQ-036 LL 0x300 then SC 0x300 store 5 -> SC issues write, wb_readData=1, link_valid=0 afterwards.
REQ-037 LL 0x300, snoop_inv 0x300 in SC issue cycle -> no dmemWEN, wb_readData=0, memwb_en=1 same cycle.
REQ-038 halt instruction passes -> HALTED, subsequent LW 0x100 produces no dmemREN, wb_halt stays 1.
REQ-039 nRST asserted during WAIT of LW -> dmemREN=0 immediately, state IDLE, wb_opcode=ADDI.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ============================================================
// cpu_types_pkg: shared CPU datapath types and opcodes
// Rev 1.0
// ============================================================
`default_nettype none

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        ADDI  = 6'b001000,
        LW    = 6'b100011,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } memst_t;
endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================
// mem_stage_if: EX/MEM inputs, data-cache port and MEM/WB outputs
// Rev 1.0
// ============================================================
`default_nettype none

interface mem_stage_if;
    import cpu_types_pkg::*;

    logic     ex_valid;
    logic     ex_dREN;
    logic     ex_dWEN;
    opcode_t  ex_opcode;
    word_t    ex_aluout;
    word_t    ex_store;
    logic     ex_regWrite;
    logic     ex_memtoReg;
    logic     ex_halt;
    regbits_t ex_wsel;
    logic     dhit;
    word_t    dmemload;
    logic     snoop_inv;
    word_t    snoop_addr;
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore;
    logic     wb_regWrite;
    logic     wb_memtoReg;
    logic     wb_halt;
    word_t    wb_readData;
    word_t    wb_aluout;
    regbits_t wb_wsel;
    opcode_t  wb_opcode;
    logic     memwb_en;
    logic     stall_up;

    // Environment side: pipeline, cache and coherence
    modport master (
        output ex_valid, ex_dREN, ex_dWEN, ex_opcode, ex_aluout, ex_store,
               ex_regWrite, ex_memtoReg, ex_halt, ex_wsel, dhit, dmemload,
               snoop_inv, snoop_addr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, wb_regWrite, wb_memtoReg,
               wb_halt, wb_readData, wb_aluout, wb_wsel, wb_opcode, memwb_en, stall_up
    );

    modport slave (
        input  ex_valid, ex_dREN, ex_dWEN, ex_opcode, ex_aluout, ex_store,
               ex_regWrite, ex_memtoReg, ex_halt, ex_wsel, dhit, dmemload,
               snoop_inv, snoop_addr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, wb_regWrite, wb_memtoReg,
               wb_halt, wb_readData, wb_aluout, wb_wsel, wb_opcode, memwb_en, stall_up
    );
endinterface

`default_nettype wire

// File: rtl/llsc_link.sv
// ============================================================
// llsc_link: load-linked reservation register with SC match
// Rev 1.0
// ============================================================
`default_nettype none

module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  word_t addr,
    input  logic  set_en,
    input  logic  sc_done,
    input  logic  st_done,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  sc_ok
);
    logic  link_valid_q, link_valid_d;
    word_t link_addr_q, link_addr_d;
    logic  snoop_hit;

    always_comb begin
        snoop_hit    = snoop_inv && (snoop_addr == link_addr_q);
        // A same-cycle invalidation beats the SC issue check
        sc_ok        = link_valid_q && (link_addr_q == addr) && !snoop_hit;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (snoop_hit || sc_done || (st_done && (addr == link_addr_q))) begin
            link_valid_d = 1'b0;
        end
        if (set_en) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================
// mem_stage: MEM pipeline stage, cache handshake, LL/SC and halt
// Rev 1.0
// ============================================================
`default_nettype none

module mem_stage
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    mem_stage_if.slave bus
);
    memst_t state_q, state_d;
    logic   is_rd, is_wr, is_sc, is_ll, is_sw;
    logic   req_rd, req_wr, wb_en, stall, sc_result, sc_ok;

    always_comb begin
        is_rd = bus.ex_valid && bus.ex_dREN;
        is_wr = bus.ex_valid && bus.ex_dWEN && !bus.ex_dREN;
        is_sc = is_wr && (bus.ex_opcode == SC);
        is_ll = is_rd && (bus.ex_opcode == LL);
        is_sw = is_wr && !is_sc;
    end

    always_comb begin
        state_d   = state_q;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        wb_en     = 1'b0;
        stall     = 1'b0;
        sc_result = 1'b0;
        unique case (state_q)
            IDLE: begin
                sc_result = sc_ok;
                if (is_rd || is_sw || (is_sc && sc_ok)) begin
                    req_rd = is_rd;
                    req_wr = is_wr;
                    if (bus.dhit) begin
                        wb_en = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                    end
                end else begin
                    wb_en = 1'b1;
                end
            end
            WAIT: begin
                // An SC only reaches WAIT after a good link check
                sc_result = 1'b1;
                req_rd    = is_rd;
                req_wr    = is_wr;
                if (bus.dhit) begin
                    wb_en   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wb_en && bus.ex_valid && bus.ex_halt) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    llsc_link u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .addr       (bus.ex_aluout),
        .set_en     (wb_en && is_ll),
        .sc_done    (wb_en && is_sc),
        .st_done    (wb_en && is_sw),
        .snoop_inv  (bus.snoop_inv),
        .snoop_addr (bus.snoop_addr),
        .sc_ok      (sc_ok)
    );

    // Outputs are gated by nRST so an asserted reset silences them at once
    assign bus.dmemREN     = nRST && req_rd;
    assign bus.dmemWEN     = nRST && req_wr;
    assign bus.dmemaddr    = nRST ? bus.ex_aluout : '0;
    assign bus.dmemstore   = nRST ? bus.ex_store : '0;
    assign bus.memwb_en    = nRST && wb_en;
    assign bus.stall_up    = nRST && stall;
    assign bus.wb_regWrite = nRST && bus.ex_valid && bus.ex_regWrite;
    assign bus.wb_memtoReg = nRST && bus.ex_memtoReg;
    assign bus.wb_halt     = nRST && ((state_q == HALTED) || (bus.ex_valid && bus.ex_halt));
    assign bus.wb_readData = !nRST ? '0 : (is_sc ? {31'b0, sc_result} : bus.dmemload);
    assign bus.wb_aluout   = nRST ? bus.ex_aluout : '0;
    assign bus.wb_wsel     = nRST ? bus.ex_wsel : '0;
    assign bus.wb_opcode   = nRST ? bus.ex_opcode : ADDI;
endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================
// tb_mem_stage: vector table, directed LL/SC/halt/reset cases, random run
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_stage;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_stage_if bus();
    mem_stage dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic    v;
        opcode_t op;
        word_t   addr;
        word_t   st;
        logic    dh;
        word_t   ld;
        logic    e_ren, e_wen, e_wb, e_stall;
        logic    c_rd;
        word_t   e_rd;
        logic    e_rw;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input opcode_t op, input word_t addr, input word_t st,
                         input logic halt, input logic dh, input word_t ld);
        bus.ex_valid    = v;
        bus.ex_opcode   = op;
        bus.ex_dREN     = (op == LW) || (op == LL);
        bus.ex_dWEN     = (op == SW) || (op == SC);
        bus.ex_aluout   = addr;
        bus.ex_store    = st;
        bus.ex_halt     = halt;
        bus.ex_regWrite = (op != SW);
        bus.ex_memtoReg = (op == LW) || (op == LL);
        bus.ex_wsel     = 5'd7;
        bus.dhit        = dh;
        bus.dmemload    = ld;
    endtask

    task automatic snoop(input logic s, input word_t a);
        bus.snoop_inv  = s;
        bus.snoop_addr = a;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    // Reference model state
    logic    m_lv;
    word_t   m_la;
    opcode_t ops[6];
    word_t   pool[4];
    opcode_t r_op;
    logic    r_v, r_rd, r_wr, r_sn, r_issue, r_dh, r_last;
    word_t   r_addr, r_st, r_sa, r_ld;
    int      r_lat, r_n;

    initial begin
        tbl[0] = '{1'b0, LW,    32'h100, 32'h0,        1'b0, 32'h55,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b1, ADDI,  32'h8,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        tbl[2] = '{1'b1, LW,    32'h100, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1};
        tbl[3] = '{1'b1, SW,    32'h200, 32'h12345678, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        tbl[4] = '{1'b1, SC,    32'h300, 32'h5,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1};
        tbl[5] = '{1'b1, RTYPE, 32'h44,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
        tbl[6] = '{1'b1, LL,    32'h304, 32'h0,        1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11,       1'b1};
        tbl[7] = '{1'b1, SC,    32'h300, 32'h9,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1};
        ops  = '{LW, LL, SW, SC, ADDI, RTYPE};
        pool = '{32'h100, 32'h200, 32'h300, 32'h304};

        // Reset state with live-looking inputs applied
        nRST = 1'b0;
        snoop(1'b0, 32'h0);
        drive(1'b1, LW, 32'h100, 32'hAA, 1'b1, 1'b1, 32'h55);
        #2;
        chk("rst_ren",    bus.dmemREN, 0);
        chk("rst_memwb",  bus.memwb_en, 0);
        chk("rst_stall",  bus.stall_up, 0);
        chk("rst_halt",   bus.wb_halt, 0);
        chk("rst_rdata",  bus.wb_readData, 0);
        chk("rst_aluout", bus.wb_aluout, 0);
        chk("rst_opcode", bus.wb_opcode, ADDI);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].addr, tbl[i].st, 1'b0, tbl[i].dh, tbl[i].ld);
            samp();
            chk($sformatf("tbl%0d_ren", i),   bus.dmemREN, tbl[i].e_ren);
            chk($sformatf("tbl%0d_wen", i),   bus.dmemWEN, tbl[i].e_wen);
            chk($sformatf("tbl%0d_memwb", i), bus.memwb_en, tbl[i].e_wb);
            chk($sformatf("tbl%0d_stall", i), bus.stall_up, tbl[i].e_stall);
            chk($sformatf("tbl%0d_rw", i),    bus.wb_regWrite, tbl[i].e_rw);
            chk($sformatf("tbl%0d_addr", i),  bus.dmemaddr, tbl[i].addr);
            chk($sformatf("tbl%0d_store", i), bus.dmemstore, tbl[i].st);
            if (tbl[i].c_rd) chk($sformatf("tbl%0d_rdata", i), bus.wb_readData, tbl[i].e_rd);
            next_cyc();
        end

        // LW with three miss cycles
        drive(1'b1, LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            samp();
            chk("lw_wait_stall", bus.stall_up, 1);
            chk("lw_wait_memwb", bus.memwb_en, 0);
            chk("lw_wait_ren",   bus.dmemREN, 1);
            chk("lw_wait_addr",  bus.dmemaddr, 32'h100);
            next_cyc();
        end
        drive(1'b1, LW, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        samp();
        chk("lw_hit_memwb", bus.memwb_en, 1);
        chk("lw_hit_stall", bus.stall_up, 0);
        chk("lw_hit_rdata", bus.wb_readData, 32'hDEADBEEF);
        next_cyc();

        // LL then SC succeeds, a second SC fails
        drive(1'b1, LL, 32'h300, 32'h0, 1'b0, 1'b1, 32'h77);
        samp();
        chk("ll_ren", bus.dmemREN, 1);
        next_cyc();
        drive(1'b1, SC, 32'h300, 32'h5, 1'b0, 1'b1, 32'h0);
        samp();
        chk("sc_wen",   bus.dmemWEN, 1);
        chk("sc_ren",   bus.dmemREN, 0);
        chk("sc_store", bus.dmemstore, 32'h5);
        chk("sc_rdata", bus.wb_readData, 1);
        chk("sc_memwb", bus.memwb_en, 1);
        next_cyc();
        samp();
        chk("sc2_wen",   bus.dmemWEN, 0);
        chk("sc2_rdata", bus.wb_readData, 0);
        next_cyc();

        // Snoop in the SC issue cycle kills the SC
        drive(1'b1, LL, 32'h300, 32'h0, 1'b0, 1'b1, 32'h0);
        next_cyc();
        drive(1'b1, SC, 32'h300, 32'h5, 1'b0, 1'b1, 32'h0);
        snoop(1'b1, 32'h300);
        samp();
        chk("scsn_wen",   bus.dmemWEN, 0);
        chk("scsn_rdata", bus.wb_readData, 0);
        chk("scsn_memwb", bus.memwb_en, 1);
        next_cyc();
        snoop(1'b0, 32'h0);

        // Snoop while the SC write is outstanding does not abort it
        drive(1'b1, LL, 32'h300, 32'h0, 1'b0, 1'b1, 32'h0);
        next_cyc();
        drive(1'b1, SC, 32'h300, 32'h6, 1'b0, 1'b0, 32'h0);
        samp();
        chk("scw_wen0", bus.dmemWEN, 1);
        next_cyc();
        snoop(1'b1, 32'h300);
        samp();
        chk("scw_wen1",  bus.dmemWEN, 1);
        chk("scw_stall", bus.stall_up, 1);
        next_cyc();
        snoop(1'b0, 32'h0);
        bus.dhit = 1'b1;
        samp();
        chk("scw_memwb", bus.memwb_en, 1);
        chk("scw_rdata", bus.wb_readData, 1);
        next_cyc();

        // Own store to the linked word breaks the link
        drive(1'b1, LL, 32'h300, 32'h0, 1'b0, 1'b1, 32'h0);
        next_cyc();
        drive(1'b1, SW, 32'h300, 32'h1, 1'b0, 1'b1, 32'h0);
        next_cyc();
        drive(1'b1, SC, 32'h300, 32'h2, 1'b0, 1'b1, 32'h0);
        samp();
        chk("swclr_wen",   bus.dmemWEN, 0);
        chk("swclr_rdata", bus.wb_readData, 0);
        next_cyc();

        // Randomised run against a transaction-level model
        nRST = 1'b0;
        next_cyc();
        nRST = 1'b1;
        m_lv = 1'b0;
        m_la = '0;
        for (int n = 0; n < 400; n++) begin
            r_op    = ops[$urandom_range(0, 5)];
            r_v     = ($urandom_range(0, 9) != 0);
            r_addr  = pool[$urandom_range(0, 3)];
            r_st    = $urandom;
            r_lat   = $urandom_range(0, 2);
            r_rd    = (r_op == LW) || (r_op == LL);
            r_wr    = (r_op == SW) || (r_op == SC);
            r_sn    = ($urandom_range(0, 3) == 0);
            r_sa    = pool[$urandom_range(0, 3)];
            r_issue = r_v && (r_rd || (r_op == SW) ||
                      ((r_op == SC) && m_lv && (m_la == r_addr) && !(r_sn && (r_sa == m_la))));
            r_n     = r_issue ? r_lat + 1 : 1;
            for (int c = 0; c < r_n; c++) begin
                if (c > 0) begin
                    r_sn = ($urandom_range(0, 3) == 0);
                    r_sa = pool[$urandom_range(0, 3)];
                end
                r_ld   = $urandom;
                r_dh   = r_issue ? (c == r_lat) : 1'($urandom_range(0, 1));
                r_last = (c == r_n - 1);
                drive(r_v, r_op, r_addr, r_st, 1'b0, r_dh, r_ld);
                snoop(r_sn, r_sa);
                samp();
                chk("rnd_ren",   bus.dmemREN, r_issue && r_rd);
                chk("rnd_wen",   bus.dmemWEN, r_issue && r_wr);
                chk("rnd_memwb", bus.memwb_en, r_last);
                chk("rnd_stall", bus.stall_up, !r_last);
                chk("rnd_rw",    bus.wb_regWrite, r_v && (r_op != SW));
                chk("rnd_halt",  bus.wb_halt, 0);
                if (r_last) chk("rnd_opcode", bus.wb_opcode, r_op);
                if (r_last && r_v && r_rd) chk("rnd_ld_data", bus.wb_readData, r_ld);
                if (r_last && r_v && (r_op == SC)) chk("rnd_sc_data", bus.wb_readData, {31'b0, r_issue});
                if (r_sn && (r_sa == m_la)) m_lv = 1'b0;
                if (r_last && r_v) begin
                    if ((r_op == SW) && (r_addr == m_la)) m_lv = 1'b0;
                    if (r_op == SC) m_lv = 1'b0;
                    if (r_op == LL) begin
                        m_lv = 1'b1;
                        m_la = r_addr;
                    end
                end
                next_cyc();
            end
        end
        snoop(1'b0, 32'h0);

        // Halt is sticky and blocks later memory ops
        drive(1'b1, ADDI, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        samp();
        chk("halt_memwb", bus.memwb_en, 1);
        chk("halt_flag",  bus.wb_halt, 1);
        next_cyc();
        drive(1'b1, LW, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0);
        for (int c = 0; c < 3; c++) begin
            samp();
            chk("halted_ren",   bus.dmemREN, 0);
            chk("halted_memwb", bus.memwb_en, 0);
            chk("halted_stall", bus.stall_up, 1);
            chk("halted_flag",  bus.wb_halt, 1);
            next_cyc();
        end

        // Reset asserted in the middle of a load miss
        nRST = 1'b0;
        next_cyc();
        nRST = 1'b1;
        drive(1'b1, LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        samp();
        chk("rw_stall", bus.stall_up, 1);
        next_cyc();
        samp();
        chk("rw_ren_before", bus.dmemREN, 1);
        #1 nRST = 1'b0;
        #1;
        chk("rw_ren",    bus.dmemREN, 0);
        chk("rw_memwb",  bus.memwb_en, 0);
        chk("rw_stall0", bus.stall_up, 0);
        chk("rw_opcode", bus.wb_opcode, ADDI);
        @(posedge CLK);
        #1 nRST = 1'b1;
        drive(1'b1, ADDI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        samp();
        chk("rw_idle_memwb", bus.memwb_en, 1);
        chk("rw_idle_stall", bus.stall_up, 0);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
